// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory behind ready/valid request/response channels.
// WAIT_CYCLES wait states precede each commit. Define DMEM_RANGE_CHECK_EN to reject addresses beyond the array.
//
// state    | meaning
// ---------+------------------------------------------------------
// S_IDLE   | req_ready=1, waiting for a request
// S_WAIT   | request latched, counting down wait states
// S_COMMIT | one cycle, memory operation performed on its edge
// S_RESP   | rsp_valid=1, held until rsp_ready
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_COMMIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         be_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  logic accept;
  logic commit_en;
  logic rsp_clr;

  logic [ADDR_WIDTH-1:0] widx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_bad;
  logic [DATA_WIDTH-1:0] merged_word;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_COMMIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_COMMIT: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output / control decode
  always_comb begin
    req_ready = 1'b0;
    commit_en = 1'b0;
    rsp_clr   = 1'b0;
    case (state_q)
      S_IDLE:   req_ready = 1'b1;
      S_COMMIT: commit_en = 1'b1;
      S_RESP:   rsp_clr   = rsp_ready;
      default:  req_ready = 1'b0;
    endcase
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  assign widx       = addr_q[ADDR_WIDTH+1:2];
  assign misaligned = |addr_q[1:0];

`ifdef DMEM_RANGE_CHECK_EN
  assign out_of_range = |addr_q[DATA_WIDTH-1:ADDR_WIDTH+2];
`else
  // Upper address bits alias; they take no part in decode.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[DATA_WIDTH-1:ADDR_WIDTH+2];
  assign out_of_range   = 1'b0;
`endif

  assign req_bad = misaligned || out_of_range;

  always_comb begin
    merged_word = mem_q[widx];
    for (int b = 0; b < NB; b++) begin
      if (be_q[b]) begin
        merged_word[b*8 +: 8] = wdata_q[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit_en && we_q && !req_bad) begin
      mem_q[widx] <= merged_word;
    end
  end

  // Response registers: loaded on the commit edge, cleared on the handshake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (commit_en) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= req_bad;
      rsp_rdata_q <= (we_q || req_bad) ? '0 : mem_q[widx];
    end else if (rsp_clr) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
